// File: rtl/ans_encoder_if.sv
// Symbol-in / nibble-out handshake bundle for the streaming rANS encoder.
// The encoder takes the slave side; its upstream and downstream take the master side.
interface ans_encoder_if #(
    parameter int SYM_WIDTH = 4
) ();
    logic [SYM_WIDTH-1:0] in;
    logic                 in_vld;
    logic                 in_rdy;
    logic                 flush;
    logic [SYM_WIDTH-1:0] out;
    logic                 out_vld;
    logic                 out_rdy;
    logic                 out_last;

    modport master (
        output in, in_vld, flush, out_rdy,
        input  in_rdy, out, out_vld, out_last
    );

    modport slave (
        input  in, in_vld, flush, out_rdy,
        output in_rdy, out, out_vld, out_last
    );
endinterface

// File: rtl/ans_encoder.sv
// Streaming rANS encoder: renormalises by nibbles, divides x by count[s] bit-serially,
// then folds in q*M + start(s) + r; a flush streams the final state out LSB nibble first.
module ans_encoder #(
    parameter int SYM_WIDTH   = 4,
    parameter int CNT_WIDTH   = 4,
    parameter int SYM_COUNT   = 16,
    parameter int STATE_WIDTH = 16
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       ena,
    input  logic [CNT_WIDTH*SYM_COUNT-1:0]             counts_unpacked,
    input  logic [(CNT_WIDTH+SYM_WIDTH)*SYM_COUNT-1:0] cumulative_unpacked,
    ans_encoder_if.slave                               bus,
    output logic                                       err
);
    localparam int CUM_WIDTH     = CNT_WIDTH + SYM_WIDTH;
    localparam int PROD_WIDTH    = STATE_WIDTH + CUM_WIDTH;
    localparam int NIBS          = STATE_WIDTH / SYM_WIDTH;
    localparam int DIV_CNT_WIDTH = $clog2(STATE_WIDTH);
    localparam int NIB_CNT_WIDTH = $clog2(NIBS + 1);

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_RENORM = 3'd2,
        ST_DIVIDE = 3'd3,
        ST_UPDATE = 3'd4,
        ST_FLUSH  = 3'd5
    } state_t;

    state_t                   state_r;
    logic [STATE_WIDTH-1:0]   x_r;
    logic [STATE_WIDTH-1:0]   q_r;
    logic [CNT_WIDTH-1:0]     rem_r;
    logic [SYM_WIDTH-1:0]     s_r;
    logic [DIV_CNT_WIDTH-1:0] div_cnt_r;
    logic [NIB_CNT_WIDTH-1:0] nib_cnt_r;
    logic                     in_rdy_r;
    logic [SYM_WIDTH-1:0]     out_r;
    logic                     out_vld_r;
    logic                     out_last_r;
    logic                     err_r;

    logic [CUM_WIDTH-1:0]     m_s;
    logic [CNT_WIDTH-1:0]     in_cnt_s;
    logic [CNT_WIDTH-1:0]     cur_cnt_s;
    logic [CUM_WIDTH-1:0]     cur_start_s;
    logic [STATE_WIDTH-1:0]   thr_s;
    logic [STATE_WIDTH-1:0]   x_sh_s;
    logic [CNT_WIDTH:0]       rem_sh_s;
    logic [CNT_WIDTH:0]       rem_diff_s;
    logic [CNT_WIDTH-1:0]     rem_nxt_s;
    logic [STATE_WIDTH-1:0]   upd_s;

    function automatic logic [CNT_WIDTH-1:0] count_of(input logic [SYM_WIDTH-1:0] s);
        logic [CNT_WIDTH-1:0] c;
        c = {CNT_WIDTH{1'b0}};
        for (int i = 0; i < SYM_COUNT; i++) begin
            if (s == SYM_WIDTH'(i)) c = counts_unpacked[i*CNT_WIDTH +: CNT_WIDTH];
        end
        return c;
    endfunction

    function automatic logic [CUM_WIDTH-1:0] start_of(input logic [SYM_WIDTH-1:0] s);
        logic [CUM_WIDTH-1:0] st;
        st = {CUM_WIDTH{1'b0}};
        for (int i = 1; i < SYM_COUNT; i++) begin
            if (s == SYM_WIDTH'(i)) st = cumulative_unpacked[(i-1)*CUM_WIDTH +: CUM_WIDTH];
        end
        return st;
    endfunction

    // Table lookups, renorm threshold and one restoring-division step (MSB of rem_diff_s is the borrow).
    always_comb begin
        m_s         = cumulative_unpacked[(SYM_COUNT-1)*CUM_WIDTH +: CUM_WIDTH];
        in_cnt_s    = count_of(bus.in);
        cur_cnt_s   = count_of(s_r);
        cur_start_s = start_of(s_r);
        thr_s       = STATE_WIDTH'({cur_cnt_s, {SYM_WIDTH{1'b0}}});
        x_sh_s      = x_r >> SYM_WIDTH;
        rem_sh_s    = {rem_r, q_r[STATE_WIDTH-1]};
        rem_diff_s  = rem_sh_s - {1'b0, cur_cnt_s};
        if (rem_diff_s[CNT_WIDTH]) begin
            rem_nxt_s = rem_sh_s[CNT_WIDTH-1:0];
        end else begin
            rem_nxt_s = rem_diff_s[CNT_WIDTH-1:0];
        end
        upd_s = STATE_WIDTH'(PROD_WIDTH'(q_r) * PROD_WIDTH'(m_s)
                             + PROD_WIDTH'(cur_start_s) + PROD_WIDTH'(rem_r));
    end

    // Encoder FSM; every register freezes while ena is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_INIT;
            x_r        <= {STATE_WIDTH{1'b0}};
            q_r        <= {STATE_WIDTH{1'b0}};
            rem_r      <= {CNT_WIDTH{1'b0}};
            s_r        <= {SYM_WIDTH{1'b0}};
            div_cnt_r  <= {DIV_CNT_WIDTH{1'b0}};
            nib_cnt_r  <= {NIB_CNT_WIDTH{1'b0}};
            in_rdy_r   <= 1'b0;
            out_r      <= {SYM_WIDTH{1'b0}};
            out_vld_r  <= 1'b0;
            out_last_r <= 1'b0;
            err_r      <= 1'b0;
        end else if (ena) begin
            case (state_r)
                ST_INIT: begin
                    x_r      <= STATE_WIDTH'(m_s);
                    in_rdy_r <= 1'b1;
                    state_r  <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (bus.in_vld) begin
                        s_r <= bus.in;
                        if (in_cnt_s == {CNT_WIDTH{1'b0}}) begin
                            err_r <= 1'b1;
                        end else begin
                            in_rdy_r <= 1'b0;
                            state_r  <= ST_RENORM;
                        end
                    end else if (bus.flush) begin
                        in_rdy_r   <= 1'b0;
                        out_r      <= x_r[SYM_WIDTH-1:0];
                        out_vld_r  <= 1'b1;
                        out_last_r <= (NIBS == 1);
                        nib_cnt_r  <= NIB_CNT_WIDTH'(NIBS);
                        state_r    <= ST_FLUSH;
                    end
                end
                ST_RENORM: begin
                    // Present a nibble, retire it on transfer, then re-test on the shifted state.
                    if (out_vld_r) begin
                        if (bus.out_rdy) begin
                            x_r       <= x_sh_s;
                            out_vld_r <= 1'b0;
                        end
                    end else if (x_r >= thr_s) begin
                        out_r     <= x_r[SYM_WIDTH-1:0];
                        out_vld_r <= 1'b1;
                    end else begin
                        q_r       <= x_r;
                        rem_r     <= {CNT_WIDTH{1'b0}};
                        div_cnt_r <= {DIV_CNT_WIDTH{1'b0}};
                        state_r   <= ST_DIVIDE;
                    end
                end
                ST_DIVIDE: begin
                    // q_r shifts the dividend out from the top while quotient bits enter at the bottom.
                    q_r       <= {q_r[STATE_WIDTH-2:0], ~rem_diff_s[CNT_WIDTH]};
                    rem_r     <= rem_nxt_s;
                    div_cnt_r <= div_cnt_r + DIV_CNT_WIDTH'(1);
                    if (div_cnt_r == DIV_CNT_WIDTH'(STATE_WIDTH - 1)) state_r <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    x_r      <= upd_s;
                    in_rdy_r <= 1'b1;
                    state_r  <= ST_IDLE;
                end
                ST_FLUSH: begin
                    if (bus.out_rdy) begin
                        x_r <= x_sh_s;
                        if (nib_cnt_r > NIB_CNT_WIDTH'(1)) begin
                            out_r      <= x_sh_s[SYM_WIDTH-1:0];
                            out_last_r <= (nib_cnt_r == NIB_CNT_WIDTH'(2));
                            nib_cnt_r  <= nib_cnt_r - NIB_CNT_WIDTH'(1);
                        end else begin
                            out_vld_r  <= 1'b0;
                            out_last_r <= 1'b0;
                            state_r    <= ST_INIT;
                        end
                    end
                end
                default: begin
                    state_r <= ST_INIT;
                end
            endcase
        end
    end

    assign bus.in_rdy   = in_rdy_r;
    assign bus.out      = out_r;
    assign bus.out_vld  = out_vld_r;
    assign bus.out_last = out_last_r;
    assign err          = err_r;
endmodule

// File: tb/tb_ans_encoder.sv
// Directed bench for ans_encoder with a two-symbol alphabet; expected values are worked by hand.
module tb_ans_encoder;
    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [7:0]  counts;
    logic [15:0] cums;
    logic        err;
    int          checks = 0;
    int          errors = 0;
    logic [4:0]  nib_q[$];
    logic [4:0]  got;
    logic [4:0]  exp4 [4];
    logic [4:0]  exp5 [5];

    ans_encoder_if #(.SYM_WIDTH(4)) bus ();

    ans_encoder #(.SYM_WIDTH(4), .CNT_WIDTH(4), .SYM_COUNT(2), .STATE_WIDTH(16)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .ena                 (ena),
        .counts_unpacked     (counts),
        .cumulative_unpacked (cums),
        .bus                 (bus.slave),
        .err                 (err)
    );

    always #5 clk = ~clk;

    // Record every nibble transfer as {last, nibble}, sampled half a cycle before its edge.
    always @(negedge clk) begin
        if (!rst && ena && bus.out_vld && bus.out_rdy) nib_q.push_back({bus.out_last, bus.out});
    end

    task automatic restart(input logic [3:0] c0, input logic [3:0] c1);
        counts     = {c1, c0};
        cums[7:0]  = {4'd0, c0};
        cums[15:8] = {4'd0, c0} + {4'd0, c1};
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        nib_q.delete();
    endtask

    task automatic send_sym(input logic [3:0] s, output int lat);
        int n;
        n = 0;
        bus.in = s;
        bus.in_vld = 1'b1;
        @(negedge clk);
        while (!bus.in_rdy && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1 bus.in_vld = 1'b0;
        lat = 0;
        while (!bus.in_rdy && lat < 200) begin @(posedge clk); #1; lat++; end
        if (n >= 100 || lat >= 200) lat = -1;
    endtask

    task automatic do_flush(output int lat);
        int n;
        n = 0;
        bus.flush = 1'b1;
        @(negedge clk);
        while (!bus.in_rdy && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1 bus.flush = 1'b0;
        lat = 0;
        while (!bus.in_rdy && lat < 200) begin @(posedge clk); #1; lat++; end
        if (n >= 100 || lat >= 200) lat = -1;
    endtask

    task automatic test_reset();
        int lat;
        @(posedge clk); #1;
        checks += 5;
        if (bus.in_rdy !== 1'b0)   begin errors++; $display("FAIL rst_in_rdy got %b expected 0", bus.in_rdy); end
        if (bus.out_vld !== 1'b0)  begin errors++; $display("FAIL rst_out_vld got %b expected 0", bus.out_vld); end
        if (bus.out !== 4'h0)      begin errors++; $display("FAIL rst_out got %h expected 0", bus.out); end
        if (bus.out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last got %b expected 0", bus.out_last); end
        if (err !== 1'b0)          begin errors++; $display("FAIL rst_err got %b expected 0", err); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.in_rdy !== 1'b1) begin errors++; $display("FAIL rdy_after_release got %b expected 1", bus.in_rdy); end
        // Start a symbol, then reset asynchronously while it is dividing.
        bus.in = 4'd0; bus.in_vld = 1'b1;
        @(posedge clk); #1 bus.in_vld = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks += 2;
        if (bus.out_vld !== 1'b0) begin errors++; $display("FAIL rst_div_out_vld got %b expected 0", bus.out_vld); end
        if (bus.in_rdy !== 1'b0)  begin errors++; $display("FAIL rst_div_in_rdy got %b expected 0", bus.in_rdy); end
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.in_rdy !== 1'b1) begin errors++; $display("FAIL rdy_after_div_rst got %b expected 1", bus.in_rdy); end
        // Reset in the middle of a flush must drop out_vld at once.
        bus.flush = 1'b1;
        @(posedge clk); #1 bus.flush = 1'b0;
        @(posedge clk); #2;
        checks++;
        if (bus.out_vld !== 1'b1) begin errors++; $display("FAIL flush_started got %b expected 1", bus.out_vld); end
        rst = 1'b1;
        #1;
        checks += 2;
        if (bus.out_vld !== 1'b0)  begin errors++; $display("FAIL rst_flush_out_vld got %b expected 0", bus.out_vld); end
        if (bus.out_last !== 1'b0) begin errors++; $display("FAIL rst_flush_out_last got %b expected 0", bus.out_last); end
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        nib_q.delete();
        do_flush(lat);
        exp4 = '{5'h04, 5'h00, 5'h00, 5'h10};
        checks += 2;
        if (lat !== 5) begin errors++; $display("FAIL rst_flush_lat got %0d expected 5", lat); end
        if (nib_q.size() !== 4) begin errors++; $display("FAIL rst_flush_count got %0d expected 4", nib_q.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < nib_q.size()) ? nib_q[i] : 5'h1f;
            checks++;
            if (got !== exp4[i]) begin errors++; $display("FAIL rst_flush_nib%0d got %h expected %h", i, got, exp4[i]); end
        end
    endtask

    task automatic test_basic();
        int lat;
        restart(4'd3, 4'd1);
        send_sym(4'd0, lat);
        checks++;
        if (lat !== 18) begin errors++; $display("FAIL basic_lat_s0 got %0d expected 18", lat); end
        send_sym(4'd1, lat);
        checks += 2;
        if (lat !== 18) begin errors++; $display("FAIL basic_lat_s1 got %0d expected 18", lat); end
        if (nib_q.size() !== 0) begin errors++; $display("FAIL basic_no_renorm got %0d expected 0", nib_q.size()); end
        do_flush(lat);
        exp4 = '{5'h07, 5'h01, 5'h00, 5'h10};
        checks += 2;
        if (lat !== 5) begin errors++; $display("FAIL basic_flush_lat got %0d expected 5", lat); end
        if (nib_q.size() !== 4) begin errors++; $display("FAIL basic_count got %0d expected 4", nib_q.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < nib_q.size()) ? nib_q[i] : 5'h1f;
            checks++;
            if (got !== exp4[i]) begin errors++; $display("FAIL basic_nib%0d got %h expected %h", i, got, exp4[i]); end
        end
    endtask

    task automatic test_renorm();
        int lat;
        restart(4'd1, 4'd1);
        for (int k = 0; k < 3; k++) begin
            send_sym(4'd0, lat);
            checks++;
            if (lat !== 18) begin errors++; $display("FAIL renorm_lat%0d got %0d expected 18", k, lat); end
        end
        send_sym(4'd0, lat);
        checks += 2;
        if (lat !== 20) begin errors++; $display("FAIL renorm_lat3 got %0d expected 20", lat); end
        if (nib_q.size() !== 1) begin errors++; $display("FAIL renorm_count got %0d expected 1", nib_q.size()); end
        do_flush(lat);
        exp5 = '{5'h00, 5'h02, 5'h00, 5'h00, 5'h10};
        checks++;
        if (nib_q.size() !== 5) begin errors++; $display("FAIL renorm_total got %0d expected 5", nib_q.size()); end
        for (int i = 0; i < 5; i++) begin
            got = (i < nib_q.size()) ? nib_q[i] : 5'h1f;
            checks++;
            if (got !== exp5[i]) begin errors++; $display("FAIL renorm_nib%0d got %h expected %h", i, got, exp5[i]); end
        end
    endtask

    task automatic test_back_pressure();
        int lat;
        int n;
        restart(4'd1, 4'd1);
        for (int k = 0; k < 3; k++) send_sym(4'd0, lat);
        bus.out_rdy = 1'b0;
        fork
            send_sym(4'd0, lat);
            begin
                n = 0;
                @(negedge clk);
                while (!bus.out_vld && n < 50) begin @(negedge clk); n++; end
                checks++;
                if (n >= 50) begin errors++; $display("FAIL bp_vld_timeout got %0d expected <50", n); end
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    checks += 3;
                    if (bus.out_vld !== 1'b1) begin errors++; $display("FAIL bp_vld%0d got %b expected 1", i, bus.out_vld); end
                    if (bus.out !== 4'h0)     begin errors++; $display("FAIL bp_out%0d got %h expected 0", i, bus.out); end
                    if (nib_q.size() !== 0)   begin errors++; $display("FAIL bp_early%0d got %0d expected 0", i, nib_q.size()); end
                end
                bus.out_rdy = 1'b1;
            end
        join
        checks++;
        if (lat !== 25) begin errors++; $display("FAIL bp_lat got %0d expected 25", lat); end
        do_flush(lat);
        exp5 = '{5'h00, 5'h02, 5'h00, 5'h00, 5'h10};
        checks++;
        if (nib_q.size() !== 5) begin errors++; $display("FAIL bp_total got %0d expected 5", nib_q.size()); end
        for (int i = 0; i < 5; i++) begin
            got = (i < nib_q.size()) ? nib_q[i] : 5'h1f;
            checks++;
            if (got !== exp5[i]) begin errors++; $display("FAIL bp_nib%0d got %h expected %h", i, got, exp5[i]); end
        end
    endtask

    task automatic test_zero_count();
        int lat;
        restart(4'd4, 4'd0);
        send_sym(4'd1, lat);
        checks += 3;
        if (lat !== 0)           begin errors++; $display("FAIL zc_lat got %0d expected 0", lat); end
        if (err !== 1'b1)        begin errors++; $display("FAIL zc_err got %b expected 1", err); end
        if (bus.in_rdy !== 1'b1) begin errors++; $display("FAIL zc_in_rdy got %b expected 1", bus.in_rdy); end
        do_flush(lat);
        exp4 = '{5'h04, 5'h00, 5'h00, 5'h10};
        checks++;
        if (nib_q.size() !== 4) begin errors++; $display("FAIL zc_count got %0d expected 4", nib_q.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < nib_q.size()) ? nib_q[i] : 5'h1f;
            checks++;
            if (got !== exp4[i]) begin errors++; $display("FAIL zc_nib%0d got %h expected %h", i, got, exp4[i]); end
        end
        nib_q.delete();
        send_sym(4'd0, lat);
        checks += 2;
        if (lat !== 18)   begin errors++; $display("FAIL zc_s0_lat got %0d expected 18", lat); end
        if (err !== 1'b1) begin errors++; $display("FAIL zc_err_sticky got %b expected 1", err); end
        do_flush(lat);
        checks++;
        if (nib_q.size() !== 4) begin errors++; $display("FAIL zc_s0_count got %0d expected 4", nib_q.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < nib_q.size()) ? nib_q[i] : 5'h1f;
            checks++;
            if (got !== exp4[i]) begin errors++; $display("FAIL zc_s0_nib%0d got %h expected %h", i, got, exp4[i]); end
        end
    endtask

    task automatic test_ena_gating();
        int lat;
        int flat;
        restart(4'd3, 4'd1);
        fork
            send_sym(4'd0, lat);
            begin
                @(negedge clk);
                @(posedge clk);
                repeat (5) @(posedge clk);
                #1 ena = 1'b0;
                repeat (3) @(posedge clk);
                #1 ena = 1'b1;
            end
        join
        checks++;
        if (lat !== 21) begin errors++; $display("FAIL ena_div_lat got %0d expected 21", lat); end
        send_sym(4'd1, lat);
        checks++;
        if (lat !== 18) begin errors++; $display("FAIL ena_s1_lat got %0d expected 18", lat); end
        fork
            do_flush(flat);
            begin
                @(negedge clk);
                @(posedge clk);
                @(posedge clk);
                #1 ena = 1'b0;
                repeat (3) @(posedge clk);
                #1 ena = 1'b1;
            end
        join
        exp4 = '{5'h07, 5'h01, 5'h00, 5'h10};
        checks += 2;
        if (flat !== 8) begin errors++; $display("FAIL ena_flush_lat got %0d expected 8", flat); end
        if (nib_q.size() !== 4) begin errors++; $display("FAIL ena_count got %0d expected 4", nib_q.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < nib_q.size()) ? nib_q[i] : 5'h1f;
            checks++;
            if (got !== exp4[i]) begin errors++; $display("FAIL ena_nib%0d got %h expected %h", i, got, exp4[i]); end
        end
    endtask

    initial begin
        rst         = 1'b1;
        ena         = 1'b1;
        counts      = {4'd1, 4'd3};
        cums        = {8'd4, 8'd3};
        bus.in      = 4'd0;
        bus.in_vld  = 1'b0;
        bus.flush   = 1'b0;
        bus.out_rdy = 1'b1;
        test_reset();
        test_basic();
        test_renorm();
        test_back_pressure();
        test_zero_count();
        test_ena_gating();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
